// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared widths, reset address, PC step and fetch FSM encoding
//                for the MIPS instruction-fetch slice.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Datapath and address width
    localparam int S = 32;

    // First fetch address after reset
    localparam logic [S-1:0] RESET_PC = 32'h0000_0000;

    // Byte distance between consecutive instruction words
    localparam logic [S-1:0] PC_INC = 32'd4;

    // Low address bits that select a byte inside a word
    localparam logic [S-1:0] BYTE_MASK = 32'd3;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // nothing outstanding
        ST_REQ   = 2'd1,   // request outstanding, response kept
        ST_DRAIN = 2'd2,   // request outstanding, response discarded
        ST_HOLD  = 2'd3    // skid full, fetching paused
    } fetch_state_t;

    // Force an address onto a word boundary
    function automatic logic [S-1:0] word_align(input logic [S-1:0] addr);
        return addr & ~BYTE_MASK;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/if_skid.sv
`default_nettype none
// ============================================================================
//  Module      : if_skid
//  Description : One-entry instruction+PC buffer that catches a fetch
//                response arriving while the output slot is stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module if_skid
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         unload,
    input  logic         flush,
    input  logic [S-1:0] in_inst,
    input  logic [S-1:0] in_pc,
    output logic [S-1:0] sk_inst,
    output logic [S-1:0] sk_pc,
    output logic         sk_valid
);

    logic [S-1:0] inst_q, inst_d;
    logic [S-1:0] pc_q,   pc_d;
    logic         valid_q, valid_d;

    // Next-entry selection: flush wins, then load, then unload
    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            inst_d  = in_inst;
            pc_d    = in_pc;
            valid_d = 1'b1;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign sk_inst  = inst_q;
    assign sk_pc    = pc_q;
    assign sk_valid = valid_q;

endmodule : if_skid
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch stage. Owns the PC, fetches words over a
//                req/ack handshake, presents inst+pc to IF/ID, absorbs one
//                in-flight response under stall and flushes on redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         reset,        // asynchronous, active-low
    input  logic         stall,
    input  logic         redirect,
    input  logic [S-1:0] redirect_pc,
    output logic         imem_req,
    output logic [S-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [S-1:0] imem_rdata,
    output logic [S-1:0] if_inst,
    output logic [S-1:0] if_pc,
    output logic         if_valid
);

    fetch_state_t state_q, state_d;
    logic [S-1:0] pc_q, pc_d;
    logic [S-1:0] req_addr_q, req_addr_d;
    logic [S-1:0] inst_q, inst_d;
    logic [S-1:0] opc_q, opc_d;
    logic         valid_q, valid_d;

    logic         sk_load, sk_unload, sk_flush;
    logic [S-1:0] sk_inst, sk_pc;
    logic         sk_valid;

    logic [S-1:0] pc_next;
    logic [S-1:0] target;
    logic         out_free;

    assign pc_next  = pc_q + PC_INC;          // wraps naturally at 2^S
    assign target   = word_align(redirect_pc);
    // Output slot can take a new word if empty or being consumed this cycle
    assign out_free = !valid_q || !stall;

    if_skid u_skid (
        .clk      (clk),
        .rst_n    (reset),
        .load     (sk_load),
        .unload   (sk_unload),
        .flush    (sk_flush),
        .in_inst  (imem_rdata),
        .in_pc    (req_addr_q),
        .sk_inst  (sk_inst),
        .sk_pc    (sk_pc),
        .sk_valid (sk_valid)
    );

    // Next-state, PC, request address and output-slot selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inst_d     = inst_q;
        opc_d      = opc_q;
        // A presented word is consumed whenever ID is not stalling
        valid_d    = valid_q && stall;
        sk_load    = 1'b0;
        sk_unload  = 1'b0;
        sk_flush   = 1'b0;

        if (redirect) begin
            // Wrong-path words are dropped from both slots, stall or not
            valid_d  = 1'b0;
            sk_flush = 1'b1;
            pc_d     = target;
            if ((state_q == ST_REQ || state_q == ST_DRAIN) && !imem_ack) begin
                // Old request still open: its response must be thrown away
                state_d = ST_DRAIN;
            end else begin
                state_d    = ST_REQ;
                req_addr_d = target;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_REQ;
                    req_addr_d = pc_q;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_next;
                        if (out_free) begin
                            inst_d     = imem_rdata;
                            opc_d      = req_addr_q;
                            valid_d    = 1'b1;
                            req_addr_d = pc_next;
                        end else begin
                            // Output slot is stuck: park the word and pause
                            sk_load = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_d    = ST_REQ;
                        req_addr_d = pc_q;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        inst_d     = sk_inst;
                        opc_d      = sk_pc;
                        valid_d    = sk_valid;
                        sk_unload  = 1'b1;
                        state_d    = ST_REQ;
                        req_addr_d = pc_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Fetch state, PC and output slot; reset takes effect without a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            inst_q     <= '0;
            opc_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            opc_q      <= opc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr = req_addr_q;
    assign if_inst   = inst_q;
    assign if_pc     = opc_q;
    assign if_valid  = valid_q;

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Scoreboard bench for if_fetch with a budgeted memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int budget = 0;      // acks the memory may still give
    int wait_n = 0;      // extra request cycles before each ack
    logic [31:0] exp_q[$];
    int pop_log[$];

    if_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_valid    (if_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && budget == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check_b(name, done, 1'b1);
    endtask

    // Memory: acks after wait_n extra cycles while budget remains
    initial begin : mem
        int cnt;
        logic prev_req, prev_ack;
        logic [31:0] prev_addr;
        cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                imem_ack = 1'b0;
                cnt = 0;
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (prev_req && !prev_ack && imem_req)
                    check("addr_stable", imem_addr, prev_addr);
                prev_req  = imem_req;
                prev_addr = imem_addr;
                imem_ack  = 1'b0;
                if (imem_req && budget > 0) begin
                    if (cnt >= wait_n) begin
                        imem_ack   = 1'b1;
                        imem_rdata = imem_addr ^ K;
                        budget--;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
                prev_ack = imem_ack;
            end
        end
    end

    // Monitor: every consumed word must match the head of the scoreboard
    initial begin : mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset && if_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h, expected no instruction", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_inst", if_inst, e ^ K);
                    pop_log.push_back(cyc);
                end
            end
        end
    end

    initial begin : stim
        // Reset state
        #2;
        check_b("rst_valid", if_valid, 1'b0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check_b("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait memory: one word per cycle from address 0
        wait_n = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        budget = 8;
        pop_log.delete();
        reset = 1'b1;
        check_b("idle_no_req", imem_req, 1'b0);
        step();
        check_b("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        check_b("first_not_valid", if_valid, 1'b0);
        step();
        check_b("first_valid", if_valid, 1'b1);
        check("first_if_pc", if_pc, 32'h0);
        wait_done("zw_drain", 50);
        check("zw_count", pop_log.size(), 32'd8);
        if (pop_log.size() == 8) check("zw_span", pop_log[7] - pop_log[0], 32'd7);

        // Wait-state memory: one word every 3 cycles
        pop_log.delete();
        wait_n = 2;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        exp_q.push_back(32'h28);
        budget = 3;
        wait_done("ws_drain", 50);
        check("ws_count", pop_log.size(), 32'd3);
        if (pop_log.size() == 3) check("ws_span", pop_log[2] - pop_log[0], 32'd6);
        check("ws_next_addr", imem_addr, 32'h2C);

        // Stall while a response is in flight
        wait_n = 0;
        stall = 1'b1;
        exp_q.push_back(32'h2C);
        budget = 1;
        step();
        step();
        check_b("st_valid", if_valid, 1'b1);
        check("st_pc", if_pc, 32'h2C);
        check("st_req_addr", imem_addr, 32'h30);
        exp_q.push_back(32'h30);
        budget = 1;
        step();
        check_b("hold_req", imem_req, 1'b0);
        check("hold_pc", if_pc, 32'h2C);
        check("hold_inst", if_inst, 32'h2C ^ K);
        step();
        check("hold_pc2", if_pc, 32'h2C);
        check_b("hold_valid2", if_valid, 1'b1);
        stall = 1'b0;
        step();
        check("unskid_pc", if_pc, 32'h30);
        check_b("unskid_valid", if_valid, 1'b1);
        check_b("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, 32'h34);
        wait_done("st_drain", 10);

        // Redirect while a request is pending
        redirect = 1'b1;
        redirect_pc = 32'h0000_0403;
        step();
        redirect = 1'b0;
        check_b("rd_valid", if_valid, 1'b0);
        check_b("drain_req", imem_req, 1'b1);
        check("drain_addr", imem_addr, 32'h34);
        budget = 1;                      // this ack must be discarded
        step();
        check("rd_target_addr", imem_addr, 32'h400);
        check_b("rd_target_req", imem_req, 1'b1);
        check_b("rd_no_valid", if_valid, 1'b0);
        exp_q.push_back(32'h400);
        budget = 1;
        wait_done("rd_drain", 10);

        // Redirect with stall asserted and skid full
        stall = 1'b1;
        budget = 2;                      // 0x404 to output, 0x408 to skid
        for (int i = 0; i < 20; i++) begin
            step();
            if (!imem_req) break;
        end
        check_b("fs_hold", imem_req, 1'b0);
        check("fs_pc", if_pc, 32'h404);
        redirect = 1'b1;
        redirect_pc = 32'h0000_1000;
        step();
        redirect = 1'b0;
        check_b("fs_flushed", if_valid, 1'b0);
        check_b("fs_req", imem_req, 1'b1);
        check("fs_addr", imem_addr, 32'h1000);
        stall = 1'b0;
        exp_q.push_back(32'h1000);
        budget = 1;
        wait_done("fs_drain", 10);

        // Wrap-around at the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        budget = 1;                      // drain the 0x1004 request
        step();
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        stall = 1'b1;
        budget = 1;
        step();
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_if_inst", if_inst, 32'hFFFF_FFFC ^ K);
        check_b("wrap_valid", if_valid, 1'b1);
        check_b("wrap_req", imem_req, 1'b1);
        check("wrap_next_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of a request
        #2;
        reset = 1'b0;
        budget = 0;
        #1;
        check_b("ar_valid", if_valid, 1'b0);
        check("ar_pc", if_pc, 32'h0);
        check("ar_inst", if_inst, 32'h0);
        check_b("ar_req", imem_req, 1'b0);
        check("ar_addr", imem_addr, 32'h0);
        stall = 1'b0;
        step();
        step();
        reset = 1'b1;
        exp_q.push_back(32'h0);
        budget = 1;
        wait_done("post_reset_drain", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_fetch
`default_nettype wire
